// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on the accepting edge and summed one
// bit per clock, LSB first. Sum, carry-out and signed overflow load together
// on the final RUN edge and hold until the next completion.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns
// the operation into a - b (b inverted, carry-in forced to 1).

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // Wide enough to hold WIDTH, so the counter never wraps during RUN.
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers, running carry, bit counter, partial-sum shifter.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Architecturally visible result registers.
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] op_b;
  logic             op_c;
  logic             s_bit;
  logic             c_next;

  assign accept   = (state_q == StIdle) && start;
  assign last_bit = (state_q == StRun) && (cnt_q == CntLast);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle, start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)    state_d = StRun;
      StRun:  if (last_bit) state_d = StDone;
      StDone:               state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  // Status outputs decoded straight from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRun:  busy = 1'b1;
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  // Operand conditioning at the accepting edge: subtraction is a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    op_b = sub ? ~b : b;
    op_c = sub ? 1'b1 : cin;
`else
    op_b = b;
    op_c = cin;
`endif
  end

  // One full-adder slice on the current LSBs of the shifting operands.
  always_comb begin
    s_bit  = a_q[0] ^ b_q[0] ^ c_q;
    c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  end

  // Datapath next state: load on accept, shift one bit per RUN edge,
  // publish the result on the last RUN edge.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    if (accept) begin
      a_d   = a;
      b_d   = op_b;
      c_d   = op_c;
      cnt_d = '0;
      acc_d = '0;
    end else if (state_q == StRun) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = c_next;
      cnt_d = cnt_q + CntOne;
      // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
      acc_d = {s_bit, acc_q[WIDTH-1:1]};
      if (last_bit) begin
        sum_d   = acc_d;
        carry_d = c_next;
        // c_q here is the carry into the MSB slice.
        ovf_d   = c_q ^ c_next;
      end
    end
  end

  // Datapath registers; reset clears operands, carry, counter and results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 instance for directed, random, back-to-back
// and reset scenarios, and a WIDTH=2 instance for an exhaustive sweep.
// Expected results come from plain integer arithmetic on the operands.

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, carry2, ovf2;
  logic [1:0] sum2;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub8 = 1'b0;
  logic sub2 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_sum8 = '0;
  logic [1:0] exp_sum2 = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ovf2)
  );

  // Reference: (a + b' + c) over w bits, b' = ~b and c = 1 when subtracting.
  // Signed overflow: operands agree in sign but the result sign differs.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, input int w, output logic [63:0] s,
                                output logic cy, output logic ov);
    logic [63:0] mask, aa, bb;
    logic [64:0] full;
    logic        c;
    mask = (64'd1 << w) - 64'd1;
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, c};
    s    = full[63:0] & mask;
    cy   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
  endfunction

  // One WIDTH=8 operation from IDLE; operands are scrambled after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                     input string name);
    logic [63:0] es;
    logic        ec, eo;
    int          lat, busy_cnt;
    model({56'd0, a}, {56'd0, b}, cin, sub, 8, es, ec, eo);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = sub;
`endif
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done8 && lat < 20) begin
      if (busy8) busy_cnt++;
      tests++;
      if (sum8 !== exp_sum8) begin
        fails++;
        $display("FAIL %s hold: sum during RUN got %h want %h", name, sum8, exp_sum8);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = 1'($urandom);
`endif
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 8) begin
      fails++;
      $display("FAIL %s latency: done after %0d edges want 8", name, lat);
    end
    tests++;
    if (busy_cnt !== 8) begin
      fails++;
      $display("FAIL %s busy: high for %0d cycles want 8", name, busy_cnt);
    end
    tests++;
    if ({busy8, ovf8, carry8, sum8} !== {1'b0, eo, ec, es[7:0]}) begin
      fails++;
      $display("FAIL %s result: busy=%b ovf=%b carry=%b sum=%h want busy=0 ovf=%b carry=%b sum=%h",
               name, busy8, ovf8, carry8, sum8, eo, ec, es[7:0]);
    end
    exp_sum8 = es[7:0];
    @(posedge clk); #1;
    tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      fails++;
      $display("FAIL %s pulse: done=%b busy=%b after DONE want 0 0", name, done8, busy8);
    end
  endtask

  // One WIDTH=2 operation from IDLE.
  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    logic [63:0] es;
    logic        ec, eo;
    int          lat;
    model({62'd0, a}, {62'd0, b}, cin, 1'b0, 2, es, ec, eo);
    a2 = a; b2 = b; cin2 = cin; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
    lat = 0;
    while (!done2 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL w2 latency a=%0d b=%0d cin=%0d: %0d edges want 2", a, b, cin, lat);
    end
    tests++;
    if ({ovf2, carry2, sum2} !== {eo, ec, es[1:0]}) begin
      fails++;
      $display("FAIL w2 result a=%0d b=%0d cin=%0d: ovf=%b carry=%b sum=%0d want %b %b %0d",
               a, b, cin, ovf2, carry2, sum2, eo, ec, es[1:0]);
    end
    exp_sum2 = es[1:0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'd0 ||
        {busy2, done2, sum2, carry2, ovf2} !== 6'd0) begin
      fails++;
      $display("FAIL reset: dut8 busy=%b done=%b sum=%h c=%b v=%b dut2 sum=%h want all 0",
               busy8, done8, sum8, carry8, ovf8, sum2);
    end
    rst = 1'b0;
    exp_sum8 = '0;
    exp_sum2 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    op8(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
    op8(8'h7F, 8'h00, 1'b1, 1'b0, "7f_cin");
    op8(8'h80, 8'h80, 1'b0, 1'b0, "neg_ovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
`else
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");
`endif
    end
  endtask

  // start held high: accepts every WIDTH+2 edges, each result tied to the
  // operands present on its accepting edge.
  task automatic test_back_to_back();
    logic [7:0]  ha[50];
    logic [7:0]  hb[50];
    logic        hc[50];
    logic [63:0] es;
    logic        ec, eo;
    int          ndone;
    ndone = 0;
    start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    for (int e = 0; e < 50; e++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      ha[e] = a8; hb[e] = b8; hc[e] = cin8;
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        tests++;
        if (e < 8 || (e % 10) != 8) begin
          fails++;
          $display("FAIL b2b timing: done at edge %0d want edges 8,18,28,...", e);
        end else begin
          model({56'd0, ha[e-8]}, {56'd0, hb[e-8]}, hc[e-8], 1'b0, 8, es, ec, eo);
          tests++;
          if ({ovf8, carry8, sum8} !== {eo, ec, es[7:0]}) begin
            fails++;
            $display("FAIL b2b result edge %0d: ovf=%b carry=%b sum=%h want %b %b %h",
                     e, ovf8, carry8, sum8, eo, ec, es[7:0]);
          end
          exp_sum8 = es[7:0];
        end
      end
    end
    start8 = 1'b0;
    tests++;
    if (ndone !== 5) begin
      fails++;
      $display("FAIL b2b count: %0d done pulses in 50 cycles want 5", ndone);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    op8(8'h12, 8'h34, 1'b1, 1'b0, "pre_rst");
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'd0) begin
      fails++;
      $display("FAIL mid_rst: busy=%b done=%b sum=%h carry=%b ovf=%b want all 0",
               busy8, done8, sum8, carry8, ovf8);
    end
    exp_sum8 = '0;
    exp_sum2 = '0;
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL mid_rst abort: %0d cycles with done/busy after reset want 0", ndone);
    end
    op8(8'h55, 8'hAA, 1'b0, 1'b0, "post_rst");
    tests++;
    if (sum8 !== 8'hFF || carry8 !== 1'b0) begin
      fails++;
      $display("FAIL post_rst literal: sum=%h carry=%b want ff 0", sum8, carry8);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    op8(8'h05, 8'h07, 1'b0, 1'b1, "sub_5_7");
    op8(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_1");
    op8(8'h33, 8'h33, 1'b0, 1'b1, "sub_eq");
  endtask
`endif

  task automatic test_w2_sweep();
    logic [1:0] aa, bb;
    for (int i = 0; i < 32; i++) begin
      aa = 2'(i >> 3);
      bb = 2'(i >> 1);
      op2(aa, bb, 1'(i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_w2_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default 8 and set the operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; SHALL be captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B; SHALL be captured on the accepting edge.
REQ-007 cin  input  1  carry-in; SHALL be captured on the accepting edge.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 carry  output  1  registered carry-out of the MSB.
REQ-012 overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at edge k SHALL latch a, b and cin, clear the bit counter and enter RUN.
REQ-015 Each RUN edge SHALL compute one bit, LSB first: s_i = a_i^b_i^c; c <= a_i&b_i | c&(a_i^b_i).
REQ-016 RUN SHALL last exactly WIDTH edges; at edge k+WIDTH sum, carry and overflow SHALL load together and the state SHALL enter DONE.
REQ-017 done SHALL be 1 only during the DONE cycle (edge k+WIDTH to k+WIDTH+1); DONE SHALL always return to IDLE on the next edge.
REQ-018 start SHALL be ignored in RUN and DONE; back-to-back operation SHALL restart no earlier than the edge after DONE (throughput: one add per WIDTH+2 cycles).
REQ-019 sum, carry and overflow SHALL hold their last result, unchanged during RUN, until the next completion.
REQ-020 Changes to a, b and cin after the accepting edge SHALL NOT affect the result.
REQ-021 The result SHALL equal (a+b+cin) mod 2^WIDTH, with carry = bit WIDTH of the full sum.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, carry=0 and overflow=0, and clear the internal operand, carry and counter registers.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start accepted after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-025 With macro SERIAL_ADDER_SUB_EN defined, an input port sub (1 bit) SHALL exist and be latched on the accepting edge.
REQ-026 With SERIAL_ADDER_SUB_EN defined and sub=1, the result SHALL be a-b: b inverted and carry-in forced to 1, ignoring cin; carry=1 means no borrow; overflow SHALL follow REQ-012 on the inverted operand.
REQ-027 Without SERIAL_ADDER_SUB_EN, the sub port and subtract logic SHALL be absent and the behaviour SHALL be addition only.

Verification
REQ-028 WIDTH=8, after reset: a=0x00, b=0x00, cin=0, start at edge k -> done exactly at edge k+8; sum=0x00, carry=0, overflow=0; busy=1 for 8 cycles.
REQ-029 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1, overflow=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, carry=0, overflow=1.
REQ-030 WIDTH=8: start held high continuously, with a/b changed every cycle during RUN -> exactly one done per 10 cycles; each result matches the operands latched on its accepting edge.
REQ-031 WIDTH=8: rst pulsed at RUN edge 4 of a=0x55, b=0xAA -> outputs go to 0 at once with no done pulse; a new start of 0x55+0xAA -> sum=0xFF, carry=0.
REQ-032 SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, a=0x05, b=0x07 -> sum=0xFE, carry=0; sub=1, a=0x80, b=0x01 -> sum=0x7F, carry=1, overflow=1.
REQ-033 WIDTH=2: exhaustive sweep of all a, b and cin -> every result matches REQ-021, with done at edge k+2.
